// File: rtl/ctrl_pkg.sv
// Shared decode/execute control-word definitions: bit positions, opcodes, ALUOp classes
// and the unpacked per-stage control bundle with its don't-care scrubbing helper.
package ctrl_pkg;

    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_MEMREAD  = 5;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_ALUOP_HI = 2;
    localparam int CTRL_ALUOP_LO = 1;
    localparam int CTRL_REGDST   = 0;

    typedef enum logic [5:0] {
        OP_R   = 6'b000000,
        OP_LW  = 6'b100011,
        OP_SW  = 6'b101011,
        OP_BEQ = 6'b000100,
        OP_J   = 6'b000010
    } opcode_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memread;
        logic       memwrite;
        logic       alusrc;
        logic [1:0] aluop;
        logic       regdst;
    } ex_ctrl_t;

    // MemtoReg/RegDst are don't-cares for non-writing ops (sw, beq); force them low.
    function automatic ex_ctrl_t unpack_ctrl(input logic [7:0] c);
        ex_ctrl_t r;
        r.regwrite = c[CTRL_REGWRITE];
        r.memtoreg = c[CTRL_REGWRITE] & c[CTRL_MEMTOREG];
        r.memread  = c[CTRL_MEMREAD];
        r.memwrite = c[CTRL_MEMWRITE];
        r.alusrc   = c[CTRL_ALUSRC];
        r.aluop    = c[CTRL_ALUOP_HI:CTRL_ALUOP_LO];
        r.regdst   = c[CTRL_REGWRITE] & c[CTRL_REGDST];
        return r;
    endfunction

endpackage

// File: rtl/id_ex_reg_if.sv
// Decode-to-execute boundary bundle: decode-side inputs, pipeline controls and EX-side outputs.
interface id_ex_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
);
    logic [CTRL_W-1:0] ctrl_i;
    logic              id_valid_i;
    logic [DATA_W-1:0] rs_data_i;
    logic [DATA_W-1:0] rt_data_i;
    logic [DATA_W-1:0] imm_i;
    logic [REG_AW-1:0] rs_i;
    logic [REG_AW-1:0] rt_i;
    logic [REG_AW-1:0] rd_i;
    logic              flush_i;
    logic              hold_i;
    logic              hazard_stall_o;
    logic              ex_valid_o;
    logic              ex_regwrite_o;
    logic              ex_memtoreg_o;
    logic              ex_memread_o;
    logic              ex_memwrite_o;
    logic              ex_alusrc_o;
    logic              ex_regdst_o;
    logic [1:0]        ex_aluop_o;
    logic [DATA_W-1:0] ex_rs_data_o;
    logic [DATA_W-1:0] ex_rt_data_o;
    logic [DATA_W-1:0] ex_imm_o;
    logic [REG_AW-1:0] ex_rs_o;
    logic [REG_AW-1:0] ex_rt_o;
    logic [REG_AW-1:0] ex_dst_o;
    logic [CNT_W-1:0]  bubble_cnt_o;

    modport slave (
        input  ctrl_i, id_valid_i, rs_data_i, rt_data_i, imm_i, rs_i, rt_i, rd_i, flush_i, hold_i,
        output hazard_stall_o, ex_valid_o, ex_regwrite_o, ex_memtoreg_o, ex_memread_o,
               ex_memwrite_o, ex_alusrc_o, ex_regdst_o, ex_aluop_o, ex_rs_data_o, ex_rt_data_o,
               ex_imm_o, ex_rs_o, ex_rt_o, ex_dst_o, bubble_cnt_o
    );

    modport master (
        output ctrl_i, id_valid_i, rs_data_i, rt_data_i, imm_i, rs_i, rt_i, rd_i, flush_i, hold_i,
        input  hazard_stall_o, ex_valid_o, ex_regwrite_o, ex_memtoreg_o, ex_memread_o,
               ex_memwrite_o, ex_alusrc_o, ex_regdst_o, ex_aluop_o, ex_rs_data_o, ex_rt_data_o,
               ex_imm_o, ex_rs_o, ex_rt_o, ex_dst_o, bubble_cnt_o
    );
endinterface

// File: rtl/id_ex_reg_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds the instruction in decode.
module hazard_detect #(
    parameter int REG_AW = 5
) (
    input  logic              ex_valid_i,
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rt_i,
    output logic              hazard_stall_o
);
    // $zero never creates a dependency, so a load targeting it is ignored.
    assign hazard_stall_o = ex_valid_i & ex_memread_i & (ex_rt_i != {REG_AW{1'b0}}) & id_valid_i
                          & ((ex_rt_i == rs_i) | (ex_rt_i == rt_i));
endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: unpacks and scrubs the decode control word, inserts bubbles on
// flush or load-use hazard, freezes on hold, and counts inserted bubbles (saturating).
module id_ex_reg
    import ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input logic    clk_i,
    input logic    rst_i,
    id_ex_if.slave bus
);
    logic [CTRL_W-1:0] ctrl_raw_s;
    ex_ctrl_t          ctrl_in_s;
    logic              stall_s;
    logic              count_s;
    logic              bubble_s;

    logic              valid_q,   valid_d;
    ex_ctrl_t          ctrl_q,    ctrl_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q,     imm_d;
    logic [REG_AW-1:0] rs_q,      rs_d;
    logic [REG_AW-1:0] rt_q,      rt_d;
    logic [REG_AW-1:0] dst_q,     dst_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    assign ctrl_raw_s = bus.ctrl_i;
    assign ctrl_in_s  = unpack_ctrl(ctrl_raw_s[7:0]);

    hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
        .ex_valid_i     (valid_q),
        .ex_memread_i   (ctrl_q.memread),
        .ex_rt_i        (rt_q),
        .id_valid_i     (bus.id_valid_i),
        .rs_i           (bus.rs_i),
        .rt_i           (bus.rt_i),
        .hazard_stall_o (stall_s)
    );

    // A coincident flush and hazard is one bubble; idle decode slots are bubbles but uncounted.
    assign count_s  = ~bus.hold_i & (bus.flush_i | stall_s);
    assign bubble_s = bus.flush_i | stall_s | ~bus.id_valid_i;

    // Next-state selection: hold, bubble or capture, plus saturating bubble counter.
    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        if (bus.hold_i) begin
            valid_d = valid_q;
        end else if (bubble_s) begin
            valid_d = 1'b0;
            ctrl_d  = ex_ctrl_t'(8'h00);
            dst_d   = {REG_AW{1'b0}};
        end else begin
            valid_d   = 1'b1;
            ctrl_d    = ctrl_in_s;
            rs_data_d = bus.rs_data_i;
            rt_data_d = bus.rt_data_i;
            imm_d     = bus.imm_i;
            rs_d      = bus.rs_i;
            rt_d      = bus.rt_i;
            if (!ctrl_in_s.regwrite) begin
                dst_d = {REG_AW{1'b0}};
            end else if (ctrl_in_s.regdst) begin
                dst_d = bus.rd_i;
            end else begin
                dst_d = bus.rt_i;
            end
        end
        if (count_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pipeline slot and counter flops.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q   <= 1'b0;
            ctrl_q    <= ex_ctrl_t'(8'h00);
            rs_data_q <= {DATA_W{1'b0}};
            rt_data_q <= {DATA_W{1'b0}};
            imm_q     <= {DATA_W{1'b0}};
            rs_q      <= {REG_AW{1'b0}};
            rt_q      <= {REG_AW{1'b0}};
            dst_q     <= {REG_AW{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            dst_q     <= dst_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.hazard_stall_o = stall_s;
    assign bus.ex_valid_o     = valid_q;
    assign bus.ex_regwrite_o  = ctrl_q.regwrite;
    assign bus.ex_memtoreg_o  = ctrl_q.memtoreg;
    assign bus.ex_memread_o   = ctrl_q.memread;
    assign bus.ex_memwrite_o  = ctrl_q.memwrite;
    assign bus.ex_alusrc_o    = ctrl_q.alusrc;
    assign bus.ex_regdst_o    = ctrl_q.regdst;
    assign bus.ex_aluop_o     = ctrl_q.aluop;
    assign bus.ex_rs_data_o   = rs_data_q;
    assign bus.ex_rt_data_o   = rt_data_q;
    assign bus.ex_imm_o       = imm_q;
    assign bus.ex_rs_o        = rs_q;
    assign bus.ex_rt_o        = rt_q;
    assign bus.ex_dst_o       = dst_q;
    assign bus.bubble_cnt_o   = cnt_q;
endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized self-checking bench for id_ex_reg against a behavioural ID/EX slot model.
module tb_id_ex_reg;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    id_ex_if #(.DATA_W(32), .REG_AW(5), .CTRL_W(8), .CNT_W(CNT_W)) bus ();

    id_ex_reg #(.DATA_W(32), .REG_AW(5), .CTRL_W(8), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the EX slot
    logic        m_valid, m_rw, m_mtr, m_mr, m_mw, m_as, m_rdst;
    logic [1:0]  m_op;
    logic [31:0] m_rsd, m_rtd, m_imm;
    logic [4:0]  m_rs, m_rt, m_dst;
    int          m_cnt;

    // Legal control words: fixed bits plus don't-care positions filled randomly
    logic [7:0] op_base [5] = '{8'b10000101, 8'b11101000, 8'b00011000, 8'b00000010, 8'b00000000};
    logic [7:0] op_dc   [5] = '{8'b00000000, 8'b00000000, 8'b01000001, 8'b01000001, 8'b00000000};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        {m_valid, m_rw, m_mtr, m_mr, m_mw, m_as, m_rdst} = 7'd0;
        m_op = 2'd0; m_rsd = 32'd0; m_rtd = 32'd0; m_imm = 32'd0;
        m_rs = 5'd0; m_rt = 5'd0; m_dst = 5'd0; m_cnt = 0;
    endtask

    function automatic logic exp_stall();
        return m_valid && m_mr && (m_rt != 5'd0) && bus.id_valid_i
               && (m_rt == bus.rs_i || m_rt == bus.rt_i);
    endfunction

    task automatic model_edge();
        logic       st;
        logic [7:0] c;
        st = exp_stall();
        c  = bus.ctrl_i;
        if (bus.hold_i) return;
        if (bus.flush_i || st) m_cnt = (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
        if (bus.flush_i || st || !bus.id_valid_i) begin
            {m_valid, m_rw, m_mtr, m_mr, m_mw, m_as, m_rdst} = 7'd0;
            m_op  = 2'd0;
            m_dst = 5'd0;
        end else begin
            m_valid = 1'b1;
            m_rw    = c[7];
            m_mtr   = c[7] ? c[6] : 1'b0;
            m_mr    = c[5];
            m_mw    = c[4];
            m_as    = c[3];
            m_op    = c[2:1];
            m_rdst  = c[7] ? c[0] : 1'b0;
            m_dst   = !c[7] ? 5'd0 : (c[0] ? bus.rd_i : bus.rt_i);
            m_rsd   = bus.rs_data_i;
            m_rtd   = bus.rt_data_i;
            m_imm   = bus.imm_i;
            m_rs    = bus.rs_i;
            m_rt    = bus.rt_i;
        end
    endtask

    task automatic check_outputs(input string ph);
        chk({ph, "_valid"},    bus.ex_valid_o,    m_valid);
        chk({ph, "_regwrite"}, bus.ex_regwrite_o, m_rw);
        chk({ph, "_memtoreg"}, bus.ex_memtoreg_o, m_mtr);
        chk({ph, "_memread"},  bus.ex_memread_o,  m_mr);
        chk({ph, "_memwrite"}, bus.ex_memwrite_o, m_mw);
        chk({ph, "_alusrc"},   bus.ex_alusrc_o,   m_as);
        chk({ph, "_regdst"},   bus.ex_regdst_o,   m_rdst);
        chk({ph, "_aluop"},    bus.ex_aluop_o,    m_op);
        chk({ph, "_rsdata"},   bus.ex_rs_data_o,  m_rsd);
        chk({ph, "_rtdata"},   bus.ex_rt_data_o,  m_rtd);
        chk({ph, "_imm"},      bus.ex_imm_o,      m_imm);
        chk({ph, "_rs"},       bus.ex_rs_o,       m_rs);
        chk({ph, "_rt"},       bus.ex_rt_o,       m_rt);
        chk({ph, "_dst"},      bus.ex_dst_o,      m_dst);
        chk({ph, "_cnt"},      bus.bubble_cnt_o,  m_cnt);
    endtask

    // Inputs already applied; check combinational stall, clock once, check registered outputs.
    task automatic tick(input string ph);
        @(negedge clk);
        chk({ph, "_stall"}, bus.hazard_stall_o, exp_stall());
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(ph);
    endtask

    task automatic drive(input logic [7:0] c, input logic v, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic fl, input logic hd);
        bus.ctrl_i = c; bus.id_valid_i = v;
        bus.rs_i = rs; bus.rt_i = rt; bus.rd_i = rd;
        bus.flush_i = fl; bus.hold_i = hd;
        bus.rs_data_i = $urandom(); bus.rt_data_i = $urandom(); bus.imm_i = $urandom();
    endtask

    function automatic logic [7:0] rand_ctrl(input int k);
        logic [7:0] r;
        r = 8'($urandom());
        return op_base[k] | (op_dc[k] & r);
    endfunction

    initial begin
        int prev;
        int guard;
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0;
        model_reset();
        drive(8'b10000101, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_outputs("reset");
        chk("reset_stall", bus.hazard_stall_o, 1'b0);
        rst_n = 1'b1;

        // R-type capture
        drive(8'b10000101, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        tick("rtype");
        chk("rtype_rw", bus.ex_regwrite_o, 1'b1);
        chk("rtype_aluop", bus.ex_aluop_o, 2'b10);
        chk("rtype_dst", bus.ex_dst_o, 5'd3);
        chk("rtype_valid", bus.ex_valid_o, 1'b1);

        // sw with random don't-care bits
        drive(rand_ctrl(2), 1'b1, 5'd4, 5'd6, 5'd7, 1'b0, 1'b0);
        tick("sw");
        chk("sw_memwrite", bus.ex_memwrite_o, 1'b1);
        chk("sw_alusrc", bus.ex_alusrc_o, 1'b1);
        chk("sw_memtoreg", bus.ex_memtoreg_o, 1'b0);
        chk("sw_regdst", bus.ex_regdst_o, 1'b0);
        chk("sw_dst", bus.ex_dst_o, 5'd0);

        // Load-use: lw rt=5 then consumer rs=5
        drive(8'b11101000, 1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0);
        tick("lw");
        drive(8'b10000101, 1'b1, 5'd5, 5'd7, 5'd8, 1'b0, 1'b0);
        #1;
        chk("lu_stall", bus.hazard_stall_o, 1'b1);
        tick("lu");
        chk("lu_bubble", bus.ex_valid_o, 1'b0);
        chk("lu_cnt", bus.bubble_cnt_o, 4'd1);

        // Load to $zero never stalls
        drive(8'b11101000, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick("lw0");
        drive(8'b10000101, 1'b1, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0);
        #1;
        chk("lw0_nostall", bus.hazard_stall_o, 1'b0);
        tick("lw0use");

        // Flush coincident with hazard: single count
        drive(8'b11101000, 1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0);
        tick("lw2");
        prev = m_cnt;
        drive(8'b10000101, 1'b1, 5'd5, 5'd1, 5'd2, 1'b1, 1'b0);
        tick("flhz");
        chk("flhz_cnt", bus.bubble_cnt_o, 64'(prev + 1));

        // Hold freezes everything, hazard still visible
        drive(8'b11101000, 1'b1, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0);
        tick("lw3");
        prev = m_cnt;
        drive(8'b10000101, 1'b1, 5'd9, 5'd1, 5'd2, 1'b1, 1'b1);
        #1;
        chk("hold_stall", bus.hazard_stall_o, 1'b1);
        tick("hold");
        chk("hold_cnt", bus.bubble_cnt_o, 64'(prev));
        chk("hold_valid", bus.ex_valid_o, 1'b1);
        chk("hold_rt", bus.ex_rt_o, 5'd9);

        // Saturation: flush up to max-1, then two more
        guard = 0;
        while (m_cnt != CNT_MAX - 1 && guard < 40) begin
            drive(8'b10000101, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
            tick("satup");
            guard++;
        end
        chk("sat_reach", bus.bubble_cnt_o, 64'(CNT_MAX - 1));
        repeat (2) begin
            drive(8'b10000101, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
            tick("sat");
        end
        chk("sat_max", bus.bubble_cnt_o, 64'(CNT_MAX));

        // Randomized traffic with a mid-stream reset
        for (int i = 0; i < 400; i++) begin
            drive(rand_ctrl(int'($urandom_range(0, 4))), ($urandom_range(0, 99) < 85),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 10));
            tick("rand");
            if (i == 200) begin
                drive(8'b10000101, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
                rst_n = 1'b0;
                #1;
                model_reset();
                check_outputs("midrst");
                rst_n = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
